gf180mcu_osu_sc_12t_aoi22_seq: RTL and testbench

Self-checking stimulus sequencer for one 12T AOI22 cell instance (Y = ~((A0&A1)|(B0&B1))) in the silicon characterization/test harness. On START it drives all 16 input combinations onto the cell, waits a programmable settle time per vector, and samples Y against the expected value. It accumulates a mismatch count and latches the first failing vector. The block sits between the harness controller and a bare cell instance and is the only driver of that cell's inputs.

---
 rtl/gf180mcu_osu_sc_12t_aoi22_seq_pkg.sv | 19 +
 rtl/gf180mcu_osu_sc_12t_aoi22_vecgen.sv | 41 ++++
 rtl/gf180mcu_osu_sc_12t_aoi22_seq.sv | 103 ++++++++++
 tb/tb_gf180mcu_osu_sc_12t_aoi22_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_osu_sc_12t_aoi22_seq_pkg.sv
// rtl/gf180mcu_osu_sc_12t_aoi22_seq_pkg.sv - shared types, sizes and expected-value function for the AOI22 sequencer
package gf180mcu_osu_sc_12t_aoi22_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  // vec = {A0,A1,B0,B1}
  function automatic logic aoi22_expect(input logic [VEC_W-1:0] vec);
    return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_aoi22_vecgen.sv
// rtl/gf180mcu_osu_sc_12t_aoi22_vecgen.sv - step counter and registered vector mapping (GF180MCU_OSU_SC_AOI22_SEQ_GRAY_EN selects Gray order)
module gf180mcu_osu_sc_12t_aoi22_vecgen
  import gf180mcu_osu_sc_12t_aoi22_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [VEC_W-1:0] vec,
  output logic             last
);

  logic [VEC_W-1:0] step;
  logic [VEC_W-1:0] step_nxt;

  function automatic logic [VEC_W-1:0] seq_map(input logic [VEC_W-1:0] n);
`ifdef GF180MCU_OSU_SC_AOI22_SEQ_GRAY_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

  assign step_nxt = step + 1'b1;
  assign last     = (step == VEC_W'(NUM_VEC - 1));

  // vec is registered from the next step so the cell inputs never glitch through the mapping
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= '0;
      vec  <= '0;
    end else if (clear) begin
      step <= '0;
      vec  <= seq_map({VEC_W{1'b0}});
    end else if (advance) begin
      step <= step_nxt;
      vec  <= seq_map(step_nxt);
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_aoi22_seq.sv
// rtl/gf180mcu_osu_sc_12t_aoi22_seq.sv - AOI22 cell stimulus sequencer top (GF180MCU_OSU_SC_AOI22_SEQ_GRAY_EN selects Gray vector order)
module gf180mcu_osu_sc_12t_aoi22_seq
  import gf180mcu_osu_sc_12t_aoi22_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y,
  output logic       A0,
  output logic       A1,
  output logic       B0,
  output logic       B1,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FIRST_FAIL_VEC
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam state_t     VEC_ENTRY   = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       settle_cnt;
  logic [VEC_W-1:0] vec;
  logic             vec_last;
  logic             vec_clear;
  logic             vec_advance;
  logic             run_start;
  logic             sample_en;
  logic             mismatch;

  gf180mcu_osu_sc_12t_aoi22_vecgen u_vecgen (
    .clk     (CLK),
    .rst     (RST),
    .clear   (vec_clear),
    .advance (vec_advance),
    .vec     (vec),
    .last    (vec_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    vec_clear   = 1'b0;
    vec_advance = 1'b0;
    run_start   = 1'b0;
    sample_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          run_start = 1'b1;
          vec_clear = 1'b1;
          state_nxt = VEC_ENTRY;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        if (vec_last) begin
          state_nxt = S_DONE;
        end else begin
          vec_advance = 1'b1;
          state_nxt   = VEC_ENTRY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter restarts from zero on every entry into SETTLE
  always_ff @(posedge CLK) begin
    if (RST || state != S_SETTLE) settle_cnt <= '0;
    else                          settle_cnt <= settle_cnt + 1'b1;
  end

  assign mismatch = (Y != aoi22_expect(vec));

  always_ff @(posedge CLK) begin
    if (RST || run_start) begin
      ERR_CNT        <= '0;
      FIRST_FAIL_VEC <= '0;
    end else if (sample_en && mismatch) begin
      ERR_CNT <= ERR_CNT + 1'b1;
      if (ERR_CNT == 5'd0) FIRST_FAIL_VEC <= vec;
    end
  end

  assign {A0, A1, B0, B1} = vec;
  assign BUSY = (state == S_SETTLE) || (state == S_SAMPLE);
  assign DONE = (state == S_DONE);
  assign FAIL = |ERR_CNT;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_aoi22_seq.sv
// tb/tb_gf180mcu_osu_sc_12t_aoi22_seq.sv - randomized self-checking bench for the AOI22 sequencer
module tb_gf180mcu_osu_sc_12t_aoi22_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a = 1'b1, start_a = 1'b0, stuck_a = 1'b0, y_a;
  logic        rst_b = 1'b1, start_b = 1'b0, stuck_b = 1'b0, y_b;
  logic [15:0] mask_a = '0, mask_b = '0;
  logic        a0_a, a1_a, b0_a, b1_a, busy_a, done_a, fail_a;
  logic        a0_b, a1_b, b0_b, b1_b, busy_b, done_b, fail_b;
  logic [4:0]  err_a, err_b;
  logic [3:0]  ffv_a, ffv_b;
  wire  [3:0]  vec_a = {a0_a, a1_a, b0_a, b1_a};
  wire  [3:0]  vec_b = {a0_b, a1_b, b0_b, b1_b};

  // Cell model: ideal AOI22 with a per-vector fault mask, or output stuck at 1
  assign y_a = stuck_a ? 1'b1 : (~((a0_a & a1_a) | (b0_a & b1_a)) ^ mask_a[vec_a]);
  assign y_b = stuck_b ? 1'b1 : (~((a0_b & a1_b) | (b0_b & b1_b)) ^ mask_b[vec_b]);

  gf180mcu_osu_sc_12t_aoi22_seq #(.SETTLE_CYCLES(2)) u_a (
    .CLK(clk), .RST(rst_a), .START(start_a), .Y(y_a),
    .A0(a0_a), .A1(a1_a), .B0(b0_a), .B1(b1_a),
    .BUSY(busy_a), .DONE(done_a), .FAIL(fail_a),
    .ERR_CNT(err_a), .FIRST_FAIL_VEC(ffv_a)
  );

  gf180mcu_osu_sc_12t_aoi22_seq #(.SETTLE_CYCLES(0)) u_b (
    .CLK(clk), .RST(rst_b), .START(start_b), .Y(y_b),
    .A0(a0_b), .A1(a1_b), .B0(b0_b), .B1(b1_b),
    .BUSY(busy_b), .DONE(done_b), .FAIL(fail_b),
    .ERR_CNT(err_b), .FIRST_FAIL_VEC(ffv_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_seq(input int n);
`ifdef GF180MCU_OSU_SC_AOI22_SEQ_GRAY_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

  function automatic bit vec_bad(input int v, input logic [15:0] mask, input bit stuck);
    bit ideal;
    ideal = !(((v >> 3) & (v >> 2) & 1) | ((v >> 1) & v & 1));
    return stuck ? !ideal : mask[v];
  endfunction

  function automatic int exp_err(input logic [15:0] mask, input bit stuck);
    int n = 0;
    for (int k = 0; k < 16; k++) if (vec_bad(ref_seq(k), mask, stuck)) n++;
    return n;
  endfunction

  function automatic int exp_ffv(input logic [15:0] mask, input bit stuck);
    for (int k = 0; k < 16; k++) if (vec_bad(ref_seq(k), mask, stuck)) return ref_seq(k);
    return 0;
  endfunction

  function automatic int get_vec(input int sel);
    return sel ? int'(vec_b) : int'(vec_a);
  endfunction
  function automatic int get_busy(input int sel);
    return sel ? int'(busy_b) : int'(busy_a);
  endfunction
  function automatic int get_done(input int sel);
    return sel ? int'(done_b) : int'(done_a);
  endfunction
  function automatic int get_fail(input int sel);
    return sel ? int'(fail_b) : int'(fail_a);
  endfunction
  function automatic int get_err(input int sel);
    return sel ? int'(err_b) : int'(err_a);
  endfunction
  function automatic int get_ffv(input int sel);
    return sel ? int'(ffv_b) : int'(ffv_a);
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start_b = v;
    else          start_a = v;
  endtask

  // Full run from IDLE/DONE: per-cycle vector/BUSY checks with random START noise, then results
  task automatic run(input int sel, input logic [15:0] mask, input bit stuck);
    int per;
    per = (sel != 0) ? 1 : 3;
    if (sel != 0) begin mask_b = mask; stuck_b = stuck; end
    else          begin mask_a = mask; stuck_a = stuck; end
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int c = 0; c < 16 * per; c++) begin
      chk($sformatf("vec[%0d] c%0d", sel, c), get_vec(sel), ref_seq(c / per));
      chk($sformatf("busy[%0d] c%0d", sel, c), get_busy(sel), 1);
      set_start(sel, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk($sformatf("done[%0d]", sel), get_done(sel), 1);
    chk($sformatf("busy_end[%0d]", sel), get_busy(sel), 0);
    chk($sformatf("err_cnt[%0d]", sel), get_err(sel), exp_err(mask, stuck));
    chk($sformatf("fail[%0d]", sel), get_fail(sel), exp_err(mask, stuck) != 0 ? 1 : 0);
    chk($sformatf("ffv[%0d]", sel), get_ffv(sel), exp_ffv(mask, stuck));
  endtask

  task automatic chk_zero(input string tag, input int sel);
    chk({tag, "_vec"},  get_vec(sel),  0);
    chk({tag, "_busy"}, get_busy(sel), 0);
    chk({tag, "_done"}, get_done(sel), 0);
    chk({tag, "_fail"}, get_fail(sel), 0);
    chk({tag, "_err"},  get_err(sel),  0);
    chk({tag, "_ffv"},  get_ffv(sel),  0);
  endtask

  initial begin
    logic [15:0] m;
    repeat (2) @(negedge clk);
    chk_zero("rst_a", 0);
    chk_zero("rst_b", 1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk_zero("idle_a", 0);

    run(0, 16'h0000, 1'b0);
    run(0, 16'h0000, 1'b1);
    chk("stuck_err_const", int'(err_a), 7);
    chk("stuck_ffv_const", int'(ffv_a), 3);
    run(1, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) run(0, 16'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) run(1, 16'($urandom), 1'b0);
    run(1, 16'h0000, 1'b1);

    // Reset at edge 20 of a run discards everything
    mask_a = 16'($urandom) | 16'h0001;
    stuck_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (19) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk_zero("midrst_a", 0);
    rst_a = 1'b0;
    run(0, 16'h0000, 1'b0);

    // START held high: ignored while busy, restarts on first DONE cycle
    m = 16'($urandom) | 16'h0001;
    mask_b = m;
    stuck_b = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    chk("held_done", int'(done_b), 1);
    chk("held_busy0", int'(busy_b), 0);
    chk("held_err", int'(err_b), exp_err(m, 1'b0));
    chk("held_ffv", int'(ffv_b), exp_ffv(m, 1'b0));
    mask_b = '0;
    @(negedge clk);
    chk("restart_busy", int'(busy_b), 1);
    chk("restart_done", int'(done_b), 0);
    chk("restart_err", int'(err_b), 0);
    chk("restart_fail", int'(fail_b), 0);
    chk("restart_vec", int'(vec_b), ref_seq(0));
    start_b = 1'b0;
    repeat (16) @(negedge clk);
    chk("restart_end_done", int'(done_b), 1);
    chk("restart_end_err", int'(err_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
